// File: rtl/rs_global_buffer_pkg.sv
// Shared constants for the row-stationary global buffer: cs/we bit positions and default word width.
package rs_gb_pkg;
    localparam int CS_FMAP        = 0;
    localparam int CS_WGT         = 1;
    localparam int DEFAULT_DATA_W = 8;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/rs_global_buffer_if.sv
// Controller-side bus of the global buffer: access strobes, addresses, write data and broadcast outputs.
interface rs_global_buffer_if #(
    parameter int DATA_W  = 8,
    parameter int FMAP_CH = 7,
    parameter int WGT_CH  = 5,
    parameter int FMAP_AW = 5,
    parameter int WGT_AW  = 6
);
    localparam int ADDR_W = rs_gb_pkg::max_w(FMAP_AW, WGT_AW);

    logic [1:0]                 cs;
    logic [1:0]                 we;
    logic [ADDR_W-1:0]          wr_addr;
    logic signed [DATA_W-1:0]   data_i;
    logic [FMAP_AW-1:0]         fmaps_addr;
    logic [WGT_AW-1:0]          weight_addr;
    logic                       swap;
    logic [FMAP_CH*DATA_W-1:0]  fmaps_o;
    logic [WGT_CH*DATA_W-1:0]   weight_o;
    logic                       fmaps_vld;
    logic                       weight_vld;
    logic                       act_bank;
    logic                       load_ready;
    logic                       swap_err;

    modport master (
        output cs, we, wr_addr, data_i, fmaps_addr, weight_addr, swap,
        input  fmaps_o, weight_o, fmaps_vld, weight_vld, act_bank, load_ready, swap_err
    );

    modport slave (
        input  cs, we, wr_addr, data_i, fmaps_addr, weight_addr, swap,
        output fmaps_o, weight_o, fmaps_vld, weight_vld, act_bank, load_ready, swap_err
    );
endinterface

// File: rtl/gb_bank.sv
// One storage bank: single write port and a registered CH-wide read whose rows wrap modulo DEPTH.
module gb_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int CH     = 7,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic                     re,
    input  logic [AW-1:0]            raddr,
    output logic [CH*DATA_W-1:0]     rdata
);
    logic signed [DATA_W-1:0] mem [DEPTH];
    logic                     re_d, re_q;
    logic [AW-1:0]            raddr_d, raddr_q;
    logic [CH*DATA_W-1:0]     rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Request is captured first; the array is gathered one edge later so reset can drop it.
    always_comb begin
        re_d    = re;
        raddr_d = raddr;
        rdata_d = rdata_q;
        if (re_q) begin
            for (int k = 0; k < CH; k++) begin
                rdata_d[k*DATA_W +: DATA_W] = mem[raddr_q + AW'(k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            re_q    <= re_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        raddr_q <= raddr_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/rs_global_buffer.sv
// Global buffer for the row-stationary PE array: fmap store plus ping-pong weight banks with fill tracking.
module rs_global_buffer import rs_gb_pkg::*; #(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FMAP_CH    = 7,
    parameter int WGT_CH     = 5,
    parameter int FMAP_DEPTH = 32,
    parameter int WGT_DEPTH  = 64
) (
    input logic           clk,
    input logic           rst,
    rs_global_buffer_if.slave bus
);
    localparam int FMAP_AW = $clog2(FMAP_DEPTH);
    localparam int WGT_AW  = $clog2(WGT_DEPTH);
    localparam int CNT_W   = WGT_AW + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WGT_DEPTH);

    logic fmap_wr, fmap_rd, wgt_wr, wgt_rd;
    logic load_bank, load_ready_c, swap_ok;
    logic [WGT_CH*DATA_W-1:0] w_rdata [2];

    logic             act_bank_d, act_bank_q;
    logic             swap_err_d, swap_err_q;
    logic [CNT_W-1:0] cnt_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic             fre_d, fre_q, fmaps_vld_d, fmaps_vld_q;
    logic             wre_d, wre_q, weight_vld_d, weight_vld_q;
    logic             wsel_d, wsel_q, osel_d, osel_q;

    // A write to a target suppresses a read of that same target in the same cycle.
    assign fmap_wr = bus.cs[CS_FMAP] & bus.we[CS_FMAP];
    assign fmap_rd = bus.cs[CS_FMAP] & ~bus.we[CS_FMAP];
    assign wgt_wr  = bus.cs[CS_WGT] & bus.we[CS_WGT];
    assign wgt_rd  = bus.cs[CS_WGT] & ~bus.we[CS_WGT];

    assign load_bank    = ~act_bank_q;
    assign load_ready_c = (cnt_q[load_bank] == CNT_FULL);
    assign swap_ok      = bus.swap & load_ready_c;

    always_comb begin
        act_bank_d   = act_bank_q ^ swap_ok;
        swap_err_d   = bus.swap & ~load_ready_c;
        cnt_d        = cnt_q;
        if (wgt_wr && (cnt_q[load_bank] != CNT_FULL)) begin
            cnt_d[load_bank] = cnt_q[load_bank] + CNT_W'(1);
        end
        // The freed bank is always the pre-swap active one, never the bank written this cycle.
        if (swap_ok) cnt_d[act_bank_q] = '0;
        fre_d        = fmap_rd;
        fmaps_vld_d  = fre_q;
        wre_d        = wgt_rd;
        wsel_d       = act_bank_q;
        weight_vld_d = wre_q;
        osel_d       = wre_q ? wsel_q : osel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_bank_q   <= 1'b0;
            swap_err_q   <= 1'b0;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            fre_q        <= 1'b0;
            fmaps_vld_q  <= 1'b0;
            wre_q        <= 1'b0;
            wsel_q       <= 1'b0;
            weight_vld_q <= 1'b0;
            osel_q       <= 1'b0;
        end else begin
            act_bank_q   <= act_bank_d;
            swap_err_q   <= swap_err_d;
            cnt_q        <= cnt_d;
            fre_q        <= fre_d;
            fmaps_vld_q  <= fmaps_vld_d;
            wre_q        <= wre_d;
            wsel_q       <= wsel_d;
            weight_vld_q <= weight_vld_d;
            osel_q       <= osel_d;
        end
    end

    gb_bank #(.DATA_W(DATA_W), .DEPTH(FMAP_DEPTH), .CH(FMAP_CH)) u_fmap (
        .clk   (clk),
        .rst   (rst),
        .we    (fmap_wr),
        .waddr (bus.wr_addr[FMAP_AW-1:0]),
        .wdata (bus.data_i),
        .re    (fmap_rd),
        .raddr (bus.fmaps_addr),
        .rdata (bus.fmaps_o)
    );

    for (genvar b = 0; b < 2; b++) begin : g_wgt
        gb_bank #(.DATA_W(DATA_W), .DEPTH(WGT_DEPTH), .CH(WGT_CH)) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (wgt_wr & (load_bank == 1'(b))),
            .waddr (bus.wr_addr[WGT_AW-1:0]),
            .wdata (bus.data_i),
            .re    (wgt_rd & (act_bank_q == 1'(b))),
            .raddr (bus.weight_addr),
            .rdata (w_rdata[b])
        );
    end

    assign bus.weight_o   = osel_q ? w_rdata[1] : w_rdata[0];
    assign bus.fmaps_vld  = fmaps_vld_q;
    assign bus.weight_vld = weight_vld_q;
    assign bus.act_bank   = act_bank_q;
    assign bus.load_ready = load_ready_c;
    assign bus.swap_err   = swap_err_q;
endmodule

// File: tb/tb_rs_global_buffer.sv
// Directed bench for rs_global_buffer: read expectations are queued when a read is issued and compared on vld.
module tb_rs_global_buffer;
    import rs_gb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs_global_buffer_if #(.DATA_W(8), .FMAP_CH(7), .WGT_CH(5), .FMAP_AW(5), .WGT_AW(6)) bus ();

    rs_global_buffer #(.DATA_W(8), .FMAP_CH(7), .WGT_CH(5), .FMAP_DEPTH(32), .WGT_DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  fmem_m [32];
    logic [7:0]  wmem_m [2][64];
    logic [55:0] fq [$];
    logic [39:0] wq [$];
    logic        fdrv, fpend, wdrv, wpend;
    logic [55:0] last_f;
    logic [39:0] last_w;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cs   = 2'b00;
        bus.we   = 2'b00;
        bus.swap = 1'b0;
    endtask

    // Advance one edge, then check vld strobes and that outputs equal the latest expected read data.
    task automatic tick();
        logic fexp, wexp;
        @(posedge clk);
        #1;
        if (rst) begin
            fexp = 1'b0; wexp = 1'b0; fpend = 1'b0; wpend = 1'b0;
            fq.delete(); wq.delete();
            last_f = '0; last_w = '0;
        end else begin
            fexp = fpend; wexp = wpend;
            fpend = fdrv; wpend = wdrv;
        end
        fdrv = 1'b0;
        wdrv = 1'b0;
        check("fmaps_vld", bus.fmaps_vld, fexp);
        check("weight_vld", bus.weight_vld, wexp);
        if (fexp && fq.size() > 0) last_f = fq.pop_front();
        if (wexp && wq.size() > 0) last_w = wq.pop_front();
        check("fmaps_o", bus.fmaps_o, last_f);
        check("weight_o", bus.weight_o, last_w);
        idle_inputs();
    endtask

    task automatic drv_fw(input int a, input logic [7:0] v);
        bus.cs[CS_FMAP] = 1'b1;
        bus.we[CS_FMAP] = 1'b1;
        bus.wr_addr     = 6'(a);
        bus.data_i      = v;
        fmem_m[a]       = v;
    endtask

    task automatic drv_fr(input int a);
        logic [55:0] e;
        bus.cs[CS_FMAP] = 1'b1;
        bus.we[CS_FMAP] = 1'b0;
        bus.fmaps_addr  = 5'(a);
        for (int k = 0; k < 7; k++) e[k*8 +: 8] = fmem_m[(a + k) % 32];
        fq.push_back(e);
        fdrv = 1'b1;
    endtask

    task automatic drv_ww(input int b, input int a, input logic [7:0] v);
        bus.cs[CS_WGT] = 1'b1;
        bus.we[CS_WGT] = 1'b1;
        bus.wr_addr    = 6'(a);
        bus.data_i     = v;
        wmem_m[b][a]   = v;
    endtask

    task automatic drv_wr(input int b, input int a);
        logic [39:0] e;
        bus.cs[CS_WGT]  = 1'b1;
        bus.we[CS_WGT]  = 1'b0;
        bus.weight_addr = 6'(a);
        for (int k = 0; k < 5; k++) e[k*8 +: 8] = wmem_m[b][(a + k) % 64];
        wq.push_back(e);
        wdrv = 1'b1;
    endtask

    initial begin
        fdrv = 1'b0; fpend = 1'b0; wdrv = 1'b0; wpend = 1'b0;
        last_f = '0; last_w = '0;
        bus.wr_addr = '0; bus.data_i = '0; bus.fmaps_addr = '0; bus.weight_addr = '0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset act_bank", bus.act_bank, 1'b0);
        check("reset load_ready", bus.load_ready, 1'b0);
        check("reset swap_err", bus.swap_err, 1'b0);

        // Fmap fill, plain read and wrap-around read
        for (int i = 0; i < 32; i++) begin drv_fw(i, 8'(i)); tick(); end
        drv_fr(3);  tick();
        drv_fr(30); tick();
        tick();
        tick();

        // Fill bank 1 and swap it in
        for (int i = 0; i < 64; i++) begin
            drv_ww(1, i, 8'(i + 1));
            tick();
            if (i == 62) check("load_ready at 63", bus.load_ready, 1'b0);
        end
        check("load_ready at 64", bus.load_ready, 1'b1);
        check("act_bank before swap", bus.act_bank, 1'b0);
        bus.swap = 1'b1; tick();
        check("act_bank after swap", bus.act_bank, 1'b1);
        check("load_ready after swap", bus.load_ready, 1'b0);
        check("swap_err ok swap", bus.swap_err, 1'b0);
        drv_wr(1, 0);  tick();
        drv_wr(1, 62); tick();
        tick();
        tick();

        // Premature swap with 63 writes
        for (int i = 0; i < 63; i++) begin drv_ww(0, i, 8'(i * 3)); tick(); end
        bus.swap = 1'b1; tick();
        check("swap_err rejected", bus.swap_err, 1'b1);
        check("act_bank rejected", bus.act_bank, 1'b1);
        tick();
        check("swap_err one cycle", bus.swap_err, 1'b0);

        // Weight write in the swap cycle lands in the pre-swap load bank
        drv_ww(0, 63, 8'hC3); tick();
        check("load_ready bank0", bus.load_ready, 1'b1);
        drv_ww(0, 0, 8'h55);
        bus.swap = 1'b1; tick();
        check("act_bank swap+write", bus.act_bank, 1'b0);
        check("load_ready freed bank", bus.load_ready, 1'b0);
        drv_wr(0, 0); tick();
        tick();

        // Weight read in the swap cycle uses the pre-swap bank
        for (int i = 0; i < 64; i++) begin drv_ww(1, i, 8'(i) ^ 8'h5A); tick(); end
        drv_wr(0, 60);
        bus.swap = 1'b1; tick();
        check("act_bank swap+read", bus.act_bank, 1'b1);
        check("load_ready cleared bank0", bus.load_ready, 1'b0);
        tick();
        drv_wr(1, 3); tick();
        tick();

        // Same-cycle fmap write and read: read suppressed, later read sees new word
        drv_fw(5, 8'hAA);
        bus.fmaps_addr = 5'd5;
        tick();
        tick();
        drv_fr(5); tick();
        tick();

        // Reset drops an in-flight read and restores bank 0
        drv_fr(0);
        drv_wr(1, 2);
        tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        check("act_bank after reset", bus.act_bank, 1'b0);
        check("load_ready after reset", bus.load_ready, 1'b0);
        check("swap_err after reset", bus.swap_err, 1'b0);
        tick();
        bus.swap = 1'b1; tick();
        check("swap_err empty bank", bus.swap_err, 1'b1);
        check("act_bank empty bank", bus.act_bank, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
